id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding front end of the EX stage.
//  Captures decoded fields from ID and forwards results from MEM/WB stages.
//  Drives the ALU operand/control inputs (in1, in2, ALUCtl, Sign) and carries
//  memory/writeback control on to EX/MEM. Also detects load-use hazards for ID.
// PARAMETERS
//  DW      32  datapath width (fixed 32 for ALU compatibility)
//  AW      5   register-address width
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  stall         in   1   downstream hold: EX contents hold (operands refresh)
//  flush         in   1   squash: bubble into EX next edge (branch/jump)
//  id_valid      in   1   ID holds a real instruction
//  id_rs_addr    in   AW  rs index;  id_rt_addr in AW rt index
//  id_rs_data    in   DW  regfile rs value;  id_rt_data in DW regfile rt value
//  id_imm        in   DW  immediate, already sign/zero extended by ID
//  id_shamt      in   5   shift amount field
//  id_dst_addr   in   AW  destination register index
//  id_alu_ctl    in   4   ALU op code;  id_sign in 1 signed-compare select
//  id_src1_shamt in   1   in1 <- shamt;  id_src2_imm in 1 in2 <- imm
//  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in 1 each
//  mem_reg_write in 1; mem_dst_addr in AW; mem_fwd_data in DW  (EX/MEM result)
//  wb_reg_write  in 1; wb_dst_addr  in AW; wb_data      in DW  (MEM/WB result)
//  alu_in1, alu_in2 out DW; alu_ctl out 4; alu_sign out 1   (to ALU)
//  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out 1
//  ex_dst_addr   out  AW  registered destination index
//  ex_store_data out  DW  forwarded rt value for stores
//  load_use      out  1   combinational: ID must hold, EX gets bubble
// BEHAVIOUR
//  - Reset (reset=0, async): every register 0 -> ex_valid=0, all controls 0,
//    alu_ctl=0, alu_in1/alu_in2 reflect zeroed state (0 unless forwarding hits).
//  - Latency: ID fields appear at EX outputs 1 cycle after capture edge.
//  - Forwarding (combinational, per operand rs/rt of EX register):
//    MEM hit (mem_reg_write & mem_dst_addr==addr & addr!=0) -> mem_fwd_data;
//    else WB hit (same rule) -> wb_data; else registered regfile data.
//    MEM has priority over WB. Register 0 never forwarded, always reads stored 0.
//  - alu_in1 = src1_shamt ? {27'b0,shamt} : fwd_rs;
//    alu_in2 = src2_imm ? imm : fwd_rt;  ex_store_data = fwd_rt always.
//  - Gating: ex_* controls and load_use are ANDed with valid;
//    alu_ctl and alu_sign pass the registered values unmasked.
//  - load_use = id_valid & ex_valid & ex_mem_read & ex_dst_addr!=0 &
//    (ex_dst_addr==id_rs_addr | ex_dst_addr==id_rt_addr).
//  - Edge update priority: flush > stall > load_use > normal load.
//    flush: valid=0, all controls 0, data don't-care (cleared to 0).
//    stall: controls/addresses/imm hold; stored rs/rt data overwritten with the
//      current forwarded values, so a WB result retiring during the hold is not
//      lost. A held instruction reads the same operand values every stalled cycle.
//    load_use (no stall): bubble, identical to flush.
//    normal: capture all id_* fields; valid <= id_valid.
//  - flush and stall together: flush wins.
//  - Reset asserted mid-stall discards the held instruction.
//  - No arithmetic performed here; widths pass unchanged; shamt zero-extended.
// TESTING
//  1 reset low with id_* nonzero -> all outputs 0, ex_valid=0; release -> next
//    edge captures ID.
//  2 addi rs=$8 (regfile 5), imm=3, no hazards -> next cycle alu_in1=5,
//    alu_in2=3, alu_ctl=0.
//  3 EX rs=$9; mem_dst=$9 data 0x11, wb_dst=$9 data 0x22 -> alu_in1=0x11;
//    drop MEM hit -> 0x22.
//  4 EX rs=$0 with mem_dst=$0, mem_reg_write=1, data 0xFF -> alu_in1=0.
//  5 lw $4 in EX, ID add rs=$4 -> load_use=1; next edge ex_valid=0, controls 0.
//  6 stall 2 cycles while WB writes $7=0xAB (EX rt=$7, once only) ->
//    alu_in2=0xAB both cycles and after release; flush+stall -> ex_valid=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Holds the decoded instruction for EX and picks the freshest operand values
// from MEM, WB or the captured register-file read data.
module id_ex_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs_addr,
   input  logic [AW-1:0] id_rt_addr,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_shamt,
   input  logic [AW-1:0] id_dst_addr,
   input  logic [3:0]    id_alu_ctl,
   input  logic          id_sign,
   input  logic          id_src1_shamt,
   input  logic          id_src2_imm,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic          mem_reg_write,
   input  logic [AW-1:0] mem_dst_addr,
   input  logic [DW-1:0] mem_fwd_data,
   input  logic          wb_reg_write,
   input  logic [AW-1:0] wb_dst_addr,
   input  logic [DW-1:0] wb_data,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   output logic [3:0]    alu_ctl,
   output logic          alu_sign,
   output logic          ex_valid,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg,
   output logic [AW-1:0] ex_dst_addr,
   output logic [DW-1:0] ex_store_data,
   output logic          load_use
);

   logic          valid_q;
   logic [AW-1:0] rs_addr_q, rt_addr_q, dst_addr_q;
   logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
   logic [4:0]    shamt_q;
   logic [3:0]    alu_ctl_q;
   logic          sign_q, src1_shamt_q, src2_imm_q;
   logic          reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic [DW-1:0] fwd_rs, fwd_rt;

   // Operand forwarding: MEM beats WB beats captured data; $0 is never forwarded.
   always_comb begin
      fwd_rs = rs_data_q;
      if (mem_reg_write && mem_dst_addr == rs_addr_q && rs_addr_q != '0) begin
         fwd_rs = mem_fwd_data;
      end else if (wb_reg_write && wb_dst_addr == rs_addr_q && rs_addr_q != '0) begin
         fwd_rs = wb_data;
      end
      fwd_rt = rt_data_q;
      if (mem_reg_write && mem_dst_addr == rt_addr_q && rt_addr_q != '0) begin
         fwd_rt = mem_fwd_data;
      end else if (wb_reg_write && wb_dst_addr == rt_addr_q && rt_addr_q != '0) begin
         fwd_rt = wb_data;
      end
   end

   // ALU operand muxing, control gating and load-use detection.
   always_comb begin
      alu_in1       = src1_shamt_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
      alu_in2       = src2_imm_q ? imm_q : fwd_rt;
      alu_ctl       = alu_ctl_q;
      alu_sign      = sign_q;
      ex_valid      = valid_q;
      ex_reg_write  = valid_q & reg_write_q;
      ex_mem_read   = valid_q & mem_read_q;
      ex_mem_write  = valid_q & mem_write_q;
      ex_mem_to_reg = valid_q & mem_to_reg_q;
      ex_dst_addr   = dst_addr_q;
      ex_store_data = fwd_rt;
      load_use      = id_valid & valid_q & mem_read_q & (dst_addr_q != '0) &
                      ((dst_addr_q == id_rs_addr) | (dst_addr_q == id_rt_addr));
   end

   // Pipeline register update: flush > stall > load-use bubble > normal capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q      <= 1'b0;
         rs_addr_q    <= '0;
         rt_addr_q    <= '0;
         dst_addr_q   <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
         shamt_q      <= '0;
         alu_ctl_q    <= '0;
         sign_q       <= 1'b0;
         src1_shamt_q <= 1'b0;
         src2_imm_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (flush || (!stall && load_use)) begin
         valid_q      <= 1'b0;
         rs_addr_q    <= '0;
         rt_addr_q    <= '0;
         dst_addr_q   <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
         shamt_q      <= '0;
         alu_ctl_q    <= '0;
         sign_q       <= 1'b0;
         src1_shamt_q <= 1'b0;
         src2_imm_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else if (stall) begin
         // Latch forwarded values so a result retiring during the hold survives.
         rs_data_q <= fwd_rs;
         rt_data_q <= fwd_rt;
      end else begin
         valid_q      <= id_valid;
         rs_addr_q    <= id_rs_addr;
         rt_addr_q    <= id_rt_addr;
         dst_addr_q   <= id_dst_addr;
         rs_data_q    <= id_rs_data;
         rt_data_q    <= id_rt_data;
         imm_q        <= id_imm;
         shamt_q      <= id_shamt;
         alu_ctl_q    <= id_alu_ctl;
         sign_q       <= id_sign;
         src1_shamt_q <= id_src1_shamt;
         src2_imm_q   <= id_src2_imm;
         reg_write_q  <= id_reg_write;
         mem_read_q   <= id_mem_read;
         mem_write_q  <= id_mem_write;
         mem_to_reg_q <= id_mem_to_reg;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use, stall/flush.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush;
   logic        id_valid;
   logic [4:0]  id_rs_addr, id_rt_addr, id_dst_addr, id_shamt;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_alu_ctl;
   logic        id_sign, id_src1_shamt, id_src2_imm;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_dst_addr, wb_dst_addr;
   logic [31:0] mem_fwd_data, wb_data;
   logic [31:0] alu_in1, alu_in2, ex_store_data;
   logic [3:0]  alu_ctl;
   logic        alu_sign, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [4:0]  ex_dst_addr;
   logic        load_use;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(32), .AW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_dst_addr(id_dst_addr), .id_alu_ctl(id_alu_ctl),
      .id_sign(id_sign), .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .mem_reg_write(mem_reg_write), .mem_dst_addr(mem_dst_addr),
      .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write),
      .wb_dst_addr(wb_dst_addr), .wb_data(wb_data),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_dst_addr(ex_dst_addr), .ex_store_data(ex_store_data), .load_use(load_use)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a full ID instruction; unlisted controls default to 0.
   task automatic id_set(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic src2, input logic [3:0] ctl,
                         input logic [4:0] dst, input logic rw, input logic mr);
      id_valid      = v;
      id_rs_addr    = rs;
      id_rs_data    = rsd;
      id_rt_addr    = rt;
      id_rt_data    = rtd;
      id_imm        = imm;
      id_src2_imm   = src2;
      id_alu_ctl    = ctl;
      id_dst_addr   = dst;
      id_reg_write  = rw;
      id_mem_read   = mr;
      id_mem_to_reg = mr;
      id_mem_write  = 1'b0;
      id_shamt      = 5'd0;
      id_sign       = 1'b0;
      id_src1_shamt = 1'b0;
   endtask

   initial begin
      // Test 1: reset held with busy ID inputs.
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_reg_write = 1'b0; mem_dst_addr = 5'd0; mem_fwd_data = 32'h0;
      wb_reg_write = 1'b0; wb_dst_addr = 5'd0; wb_data = 32'h0;
      id_set(1'b1, 5'd3, 32'h1234, 5'd4, 32'h5678, 32'h99, 1'b1, 4'h7, 5'd5, 1'b1, 1'b1);
      id_shamt = 5'd9; id_sign = 1'b1; id_mem_write = 1'b1;
      tick(); tick();
      chk("rst_valid", {31'b0, ex_valid}, 32'h0);
      chk("rst_in1", alu_in1, 32'h0);
      chk("rst_in2", alu_in2, 32'h0);
      chk("rst_ctl", {28'b0, alu_ctl}, 32'h0);
      chk("rst_sign", {31'b0, alu_sign}, 32'h0);
      chk("rst_ctrls", {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        load_use}, 32'h0);
      chk("rst_dst", {27'b0, ex_dst_addr}, 32'h0);
      chk("rst_store", ex_store_data, 32'h0);

      // Test 2: release reset, addi $9 = $8(5) + 3.
      reset = 1'b1;
      id_set(1'b1, 5'd8, 32'd5, 5'd0, 32'd0, 32'd3, 1'b1, 4'h0, 5'd9, 1'b1, 1'b0);
      tick();
      chk("addi_valid", {31'b0, ex_valid}, 32'h1);
      chk("addi_in1", alu_in1, 32'd5);
      chk("addi_in2", alu_in2, 32'd3);
      chk("addi_ctl", {28'b0, alu_ctl}, 32'h0);
      chk("addi_rw", {31'b0, ex_reg_write}, 32'h1);
      chk("addi_dst", {27'b0, ex_dst_addr}, 32'd9);

      // Test 3: EX rs=$9, MEM and WB both hit, then WB only, then neither.
      id_set(1'b1, 5'd9, 32'h1, 5'd0, 32'd0, 32'd0, 1'b0, 4'h2, 5'd10, 1'b1, 1'b0);
      tick();
      mem_reg_write = 1'b1; mem_dst_addr = 5'd9; mem_fwd_data = 32'h11;
      wb_reg_write = 1'b1; wb_dst_addr = 5'd9; wb_data = 32'h22;
      #1 chk("fwd_mem_prio", alu_in1, 32'h11);
      mem_reg_write = 1'b0;
      #1 chk("fwd_wb", alu_in1, 32'h22);
      wb_reg_write = 1'b0;
      #1 chk("fwd_none", alu_in1, 32'h1);
      chk("fwd_ctl", {28'b0, alu_ctl}, 32'h2);

      // Test 4: $0 never forwarded.
      id_set(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 4'h1, 5'd0, 1'b0, 1'b0);
      tick();
      mem_reg_write = 1'b1; mem_dst_addr = 5'd0; mem_fwd_data = 32'hFF;
      wb_reg_write = 1'b1; wb_dst_addr = 5'd0; wb_data = 32'hEE;
      #1 chk("r0_in1", alu_in1, 32'h0);
      chk("r0_store", ex_store_data, 32'h0);
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;

      // Test 5: lw $4 in EX, add using $4 in ID.
      id_set(1'b1, 5'd8, 32'd5, 5'd0, 32'd0, 32'd4, 1'b1, 4'h0, 5'd4, 1'b1, 1'b1);
      tick();
      chk("lw_mem_read", {31'b0, ex_mem_read}, 32'h1);
      chk("lw_mem_to_reg", {31'b0, ex_mem_to_reg}, 32'h1);
      id_set(1'b0, 5'd4, 32'd0, 5'd5, 32'd0, 32'd0, 1'b0, 4'h0, 5'd6, 1'b1, 1'b0);
      #1 chk("lu_no_id_valid", {31'b0, load_use}, 32'h0);
      id_valid = 1'b1;
      #1 chk("lu_rs_hit", {31'b0, load_use}, 32'h1);
      tick();
      chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
      chk("lu_bubble_ctrls", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write,
                              ex_mem_to_reg}, 32'h0);
      chk("lu_after_bubble", {31'b0, load_use}, 32'h0);
      tick();
      chk("lu_add_captured", {26'b0, ex_valid, ex_dst_addr}, {26'b0, 1'b1, 5'd6});

      // Test 6: stall while WB writes $7 for one cycle only.
      id_set(1'b1, 5'd0, 32'd0, 5'd7, 32'h1, 32'd0, 1'b0, 4'h3, 5'd11, 1'b1, 1'b0);
      tick();
      chk("st_pre", alu_in2, 32'h1);
      stall = 1'b1;
      wb_reg_write = 1'b1; wb_dst_addr = 5'd7; wb_data = 32'hAB;
      id_set(1'b1, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 1'b0, 4'h9, 5'd12, 1'b1, 1'b0);
      #1 chk("st_fwd", alu_in2, 32'hAB);
      tick();
      wb_reg_write = 1'b0;
      #1 chk("st_cyc1_in2", alu_in2, 32'hAB);
      chk("st_cyc1_store", ex_store_data, 32'hAB);
      tick();
      chk("st_cyc2_in2", alu_in2, 32'hAB);
      chk("st_hold_dst", {27'b0, ex_dst_addr}, 32'd11);
      chk("st_hold_ctl", {28'b0, alu_ctl}, 32'h3);
      chk("st_hold_valid", {31'b0, ex_valid}, 32'h1);
      stall = 1'b0;
      #1 chk("st_release_in2", alu_in2, 32'hAB);
      tick();
      chk("st_next_dst", {27'b0, ex_dst_addr}, 32'd12);
      chk("st_next_ctl", {28'b0, alu_ctl}, 32'h9);

      // Flush together with stall: flush wins.
      stall = 1'b1; flush = 1'b1;
      tick();
      chk("flush_stall_valid", {31'b0, ex_valid}, 32'h0);
      chk("flush_stall_rw", {31'b0, ex_reg_write}, 32'h0);

      // Reset in the middle of a stall drops the held instruction.
      stall = 1'b0; flush = 1'b0;
      tick();
      chk("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
      stall = 1'b1;
      tick();
      reset = 1'b0;
      #1 chk("rst_stall_valid", {31'b0, ex_valid}, 32'h0);
      chk("rst_stall_dst", {27'b0, ex_dst_addr}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
